// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl
//
// Generates the rectangle of one Pong paddle and its pixel-draw enable.
// The bar sits at a fixed x and moves vertically. In manual mode it follows
// the debounced up/down buttons. In auto mode it tracks the ball's vertical
// centre within a deadband. Movement happens only on ticks of a free-running
// divider and is clamped to the screen. Instantiate one per side.
//
// Ports:
//   PixelClock  in   clock
//   Reset       in   synchronous, active-high
//   btnUp       in   move-up request (asynchronous)
//   btnDown     in   move-down request (asynchronous)
//   autoMode    in   1 = track ball, 0 = buttons (asynchronous)
//   ballTop     in   [10:0] ball top y
//   xPos, yPos  in   [11:0] current pixel being drawn
//   barLeft     out  [10:0] left edge x
//   barRight    out  [10:0] right edge x
//   barTop      out  [10:0] top edge y
//   barBottom   out  [10:0] bottom edge y
//   drawBar     out  pixel lies strictly inside the bar
// -----------------------------------------------------------------------------
module paddle_ctrl #(
  parameter int pLeft      = 20,
  parameter int pTop       = 250,
  parameter int pWidth     = 10,
  parameter int pHeight    = 100,
  parameter int sHeight    = 600,
  parameter int ballHeight = 20,
  parameter int MOVE_DIV   = 50000,
  parameter int STEP       = 1,
  parameter int DEBOUNCE   = 20000,
  parameter int DEADBAND   = 4
) (
  input  logic        PixelClock,
  input  logic        Reset,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        autoMode,
  input  logic [10:0] ballTop,
  input  logic [11:0] xPos,
  input  logic [11:0] yPos,
  output logic [10:0] barLeft,
  output logic [10:0] barRight,
  output logic [10:0] barTop,
  output logic [10:0] barBottom,
  output logic        drawBar
);

  // Counter widths sized so the terminal values always fit, even when the
  // divider or debounce length is 1.
  localparam int TW = $clog2(MOVE_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {HOLD, UP, DOWN} state_t;

  state_t        state;
  state_t        state_next;
  logic          move_up;
  logic          move_down;

  logic [1:0]    up_sync;
  logic [1:0]    down_sync;
  logic [1:0]    auto_sync;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]    synced;
  logic [1:0]    deb;
  logic [DW-1:0] deb_cnt [2];

  logic [TW-1:0] tick_cnt;
  logic          tick;

  logic [10:0]   bar_y;
  logic [11:0]   bar_y_ext;
  logic [11:0]   ball_c;
  logic [11:0]   bar_c;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the asynchronous inputs.
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // flops update together from pre-edge values; blocking here would let a
  // later flop see an earlier flop's new value and collapse the sync chain.
  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      up_sync   <= '0;
      down_sync <= '0;
      auto_sync <= '0;
    end else begin
      up_sync   <= {up_sync[0],   btnUp};
      down_sync <= {down_sync[0], btnDown};
      auto_sync <= {auto_sync[0], autoMode};
    end
  end

  assign synced = {down_sync[1], up_sync[1]};

  // ---------------------------------------------------------------------------
  // Debounce: a new level is accepted only after it has differed from the
  // accepted level for DEBOUNCE consecutive cycles; any return clears the run.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      deb <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE - 1)) begin
          deb[i]     <= synced[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running movement tick divider; unaffected by mode or state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TW'(MOVE_DIV - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state logic / output decode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PixelClock) begin
    if (Reset) state <= HOLD;
    else       state <= state_next;
  end

  assign bar_y_ext = {1'b0, bar_y};
  assign ball_c    = {1'b0, ballTop} + 12'(ballHeight / 2);
  assign bar_c     = bar_y_ext + 12'(pHeight / 2);

  // NOTE: the default assignment at the top of this block guarantees the
  // output is written on every path, so no latch is inferred.
  always_comb begin
    state_next = HOLD;
    if (!auto_sync[1]) begin
      if (deb[0] && !deb[1])      state_next = UP;
      else if (deb[1] && !deb[0]) state_next = DOWN;
    end else begin
      if (ball_c + 12'(DEADBAND) < bar_c)      state_next = UP;
      else if (ball_c > bar_c + 12'(DEADBAND)) state_next = DOWN;
    end
  end

  always_comb begin
    move_up   = (state == UP);
    move_down = (state == DOWN);
  end

  // ---------------------------------------------------------------------------
  // Bar position: one step per tick, clamped at the top and bottom of screen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      bar_y <= 11'(pTop);
    end else if (tick) begin
      if (move_up) begin
        bar_y <= (bar_y < 11'(STEP)) ? '0 : bar_y - 11'(STEP);
      end else if (move_down) begin
        bar_y <= (bar_y_ext + 12'(pHeight) + 12'(STEP) > 12'(sHeight))
                 ? 11'(sHeight - pHeight) : bar_y + 11'(STEP);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rectangle and draw enable; strict inequalities match the ball's drawing.
  // ---------------------------------------------------------------------------
  assign barLeft   = 11'(pLeft);
  assign barRight  = 11'(pLeft + pWidth);
  assign barTop    = bar_y;
  assign barBottom = bar_y + 11'(pHeight);

  assign drawBar = (xPos > {1'b0, barLeft})  && (xPos < {1'b0, barRight}) &&
                   (yPos > {1'b0, barTop})   && (yPos < {1'b0, barBottom});

endmodule

// File: tb/tb_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_ctrl
//
// Self-checking bench for paddle_ctrl with a short tick divider and debounce.
// Draw-enable vectors come from a table and flow through an expected-value
// queue; movement, clamping, glitch rejection, auto tracking and reset are
// exercised with hand-written sequences.
// -----------------------------------------------------------------------------
module tb_paddle_ctrl;

  localparam int MOVE_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic        clk;
  logic        rst;
  logic        btn_up;
  logic        btn_down;
  logic        auto_mode;
  logic [10:0] ball_top;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [10:0] bar_left;
  logic [10:0] bar_right;
  logic [10:0] bar_top;
  logic [10:0] bar_bottom;
  logic        draw_bar;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        draw;
  } vec_t;

  vec_t vecs [10];
  logic exp_q [$];

  paddle_ctrl #(
    .MOVE_DIV (MOVE_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .PixelClock (clk),
    .Reset      (rst),
    .btnUp      (btn_up),
    .btnDown    (btn_down),
    .autoMode   (auto_mode),
    .ballTop    (ball_top),
    .xPos       (x_pos),
    .yPos       (y_pos),
    .barLeft    (bar_left),
    .barRight   (bar_right),
    .barTop     (bar_top),
    .barBottom  (bar_bottom),
    .drawBar    (draw_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Wait until barTop changes; cycles = negedges waited.
  task automatic wait_change(input int limit, output int cycles, output bit timed_out);
    logic [10:0] snap;
    snap      = bar_top;
    cycles    = 0;
    timed_out = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bar_top != snap) begin
        cycles    = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_value(input int target, input int limit, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (bar_top == 11'(target)) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Count barTop changes over n cycles.
  task automatic count_moves(input int n, output int moves);
    logic [10:0] prev;
    moves = 0;
    prev  = bar_top;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bar_top != prev) moves++;
      prev = bar_top;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  cyc;
    int  moves;
    int  wraps;
    bit  to;
    logic [10:0] prev;
    logic [10:0] snap;

    vecs[0] = '{x: 12'd25,   y: 12'd300, draw: 1'b1};
    vecs[1] = '{x: 12'd20,   y: 12'd300, draw: 1'b0};
    vecs[2] = '{x: 12'd25,   y: 12'd350, draw: 1'b0};
    vecs[3] = '{x: 12'd21,   y: 12'd251, draw: 1'b1};
    vecs[4] = '{x: 12'd29,   y: 12'd349, draw: 1'b1};
    vecs[5] = '{x: 12'd30,   y: 12'd300, draw: 1'b0};
    vecs[6] = '{x: 12'd25,   y: 12'd250, draw: 1'b0};
    vecs[7] = '{x: 12'd0,    y: 12'd0,   draw: 1'b0};
    vecs[8] = '{x: 12'd4095, y: 12'd300, draw: 1'b0};
    vecs[9] = '{x: 12'd2068, y: 12'd300, draw: 1'b0};

    rst       = 1'b1;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    auto_mode = 1'b0;
    ball_top  = 11'd0;
    x_pos     = 12'd0;
    y_pos     = 12'd0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_left",   int'(bar_left),   20);
    check("reset_right",  int'(bar_right),  30);
    check("reset_top",    int'(bar_top),    250);
    check("reset_bottom", int'(bar_bottom), 350);

    // Draw-enable table through the expected-value queue.
    foreach (vecs[i]) begin
      x_pos = vecs[i].x;
      y_pos = vecs[i].y;
      exp_q.push_back(vecs[i].draw);
      #1;
      check($sformatf("draw_vec%0d", i), int'(draw_bar), int'(exp_q.pop_front()));
      @(negedge clk);
    end

    // Two-cycle glitch on btnUp must be rejected.
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    count_moves(100, moves);
    check("glitch_moves", moves, 0);
    check("glitch_top", int'(bar_top), 250);

    // Held btnUp: first move after sync+debounce+state, then one per tick.
    btn_up = 1'b1;
    wait_change(20, cyc, to);
    check("up_first_timeout", int'(to), 0);
    check("up_first_latency_ok", int'(cyc >= 7 && cyc <= 10), 1);
    check("up_first_value", int'(bar_top), 249);
    for (int k = 2; k <= 4; k++) begin
      wait_change(20, cyc, to);
      check($sformatf("up_interval_%0d", k), cyc, MOVE_DIV);
      check($sformatf("up_value_%0d", k), int'(bar_top), 250 - k);
    end

    // Keep holding far past the top; must clamp at 0 and never wrap.
    wraps = 0;
    prev  = bar_top;
    for (int i = 0; i < 1100 * MOVE_DIV; i++) begin
      @(negedge clk);
      if (bar_top > prev) wraps++;
      prev = bar_top;
    end
    check("up_no_wrap",     wraps, 0);
    check("up_clamp_top",   int'(bar_top),    0);
    check("up_clamp_bottom", int'(bar_bottom), 100);
    btn_up = 1'b0;
    repeat (20) @(negedge clk);

    // Held btnDown: 496..500 then clamp at 500.
    btn_down = 1'b1;
    wait_value(495, 3000, to);
    check("down_reach_495_timeout", int'(to), 0);
    for (int k = 1; k <= 5; k++) begin
      wait_change(20, cyc, to);
      check($sformatf("down_value_%0d", k), int'(bar_top), 495 + k);
    end
    count_moves(40 * MOVE_DIV, moves);
    check("down_clamp_moves",  moves, 0);
    check("down_clamp_top",    int'(bar_top),    500);
    check("down_clamp_bottom", int'(bar_bottom), 600);

    // Move up a little, then hold both buttons: bar must stay put.
    btn_down = 1'b0;
    btn_up   = 1'b1;
    wait_value(490, 400, to);
    check("both_setup_timeout", int'(to), 0);
    btn_down = 1'b1;
    repeat (10) @(negedge clk);
    snap = bar_top;
    count_moves(50 * MOVE_DIV, moves);
    check("both_moves", moves, 0);
    check("both_top", int'(bar_top), int'(snap));
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (20) @(negedge clk);

    // Auto mode tracks ball centre 110 and stops at barTop 64 (centre 114).
    do_reset(2);
    check("auto_start_top", int'(bar_top), 250);
    ball_top  = 11'd100;
    auto_mode = 1'b1;
    wait_value(64, 2000, to);
    check("auto_reach_timeout", int'(to), 0);
    count_moves(25 * MOVE_DIV, moves);
    check("auto_stop_moves", moves, 0);
    check("auto_stop_top", int'(bar_top), 64);

    // Ball moves low, bar tracks downward; reset in the middle of the move.
    ball_top = 11'd500;
    wait_value(80, 400, to);
    check("auto_down_timeout", int'(to), 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_move_top", int'(bar_top), 250);
    count_moves(8, moves);
    check("reset_hold_moves", moves, 0);
    rst = 1'b0;
    // 2 sync cycles, 1 state cycle, tick on the 4th edge after release.
    wait_change(20, cyc, to);
    check("resume_timeout", int'(to), 0);
    check("resume_latency", cyc, 4);
    check("resume_value", int'(bar_top), 251);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Produces the paddle (bar) rectangle that the ball logic consumes for collision: Left/Right/Top/Bottom edges in screen pixels.
- Also produces the bar's pixel-draw enable for the top-level PongGame.
- Vertical position is driven by debounced up/down buttons, or in auto mode by tracking the ball's vertical centre.
- Movement is rate-limited by a tick divider and clamped to the screen. One instance is used per side (left and right bar).

Parameters:
- pLeft, 20, x of the bar's left edge; fixed.
- pTop, 250, y of the bar's top edge after reset.
- pWidth, 10, bar width in pixels.
- pHeight, 100, bar height in pixels.
- sHeight, 600, screen height in pixels.
- ballHeight, 20, ball height, used for the auto-mode centre.
- MOVE_DIV, 50000, PixelClock cycles per movement tick (>=1).
- STEP, 1, pixels moved per tick.
- DEBOUNCE, 20000, cycles a synced input must stay stable before it is accepted (>=1).
- DEADBAND, 4, auto-mode tolerance between centres in pixels.

Ports:
- PixelClock  in  1  clock.
- Reset  in  1  synchronous, active-high.
- btnUp  in  1  active-high move-up request; asynchronous to PixelClock.
- btnDown  in  1  active-high move-down request; asynchronous.
- autoMode  in  1  1 = track ball, 0 = buttons; asynchronous switch.
- ballTop  in  11  current top y of the ball.
- xPos  in  12  horizontal pixel counter.
- yPos  in  12  vertical pixel counter.
- barLeft  out  11  left edge x.
- barRight  out  11  right edge x.
- barTop  out  11  top edge y.
- barBottom  out  11  bottom edge y.
- drawBar  out  1  pixel lies inside the bar.

Behaviour:
- Reset (clocked when Reset=1):
  - barY=pTop; state=HOLD.
  - Tick counter=0; debounce counters=0.
  - Debounced levels=0; sync flops=0.
  - Reset wins over every other event, including mid-move and on a tick cycle.
- Synchronisers: btnUp, btnDown and autoMode each pass through a 2-flop synchroniser.
- Debounce (btnUp and btnDown only):
  - While the synced level equals the debounced level, the counter is held at 0.
  - While it differs, the counter increments each cycle.
  - When the counter = DEBOUNCE-1 and the levels still differ: debounced level <= synced level; counter <= 0.
  - Any return to equality before then clears the counter, so glitches shorter than DEBOUNCE cycles are ignored.
  - autoMode is synced only, not debounced.
- Tick counter:
  - Free-running 0..MOVE_DIV-1, wraps to 0.
  - tick=1 on the cycle the count equals MOVE_DIV-1.
  - Not cleared by a mode or state change.
- FSM (registered): states HOLD, UP, DOWN. Next state is evaluated every cycle:
  - Manual mode (synced autoMode=0):
    - up only -> UP.
    - down only -> DOWN.
    - both or neither -> HOLD.
  - Auto mode:
    - bc = ballTop + ballHeight/2; pc = barY + pHeight/2, both as 12-bit arithmetic.
    - bc + DEADBAND < pc -> UP.
    - bc > pc + DEADBAND -> DOWN.
    - otherwise HOLD.
- Movement (only on tick cycles, using the current registered state):
  - UP: barY <= (barY < STEP) ? 0 : barY - STEP. Never wraps below 0.
  - DOWN: barY <= (barY + pHeight + STEP > sHeight) ? sHeight - pHeight : barY + STEP. Compare in 12 bits; never exceeds sHeight - pHeight.
  - HOLD: barY unchanged.
- Outputs:
  - barLeft=pLeft, barRight=pLeft+pWidth, barTop=barY, barBottom=barY+pHeight.
  - All four are combinational from barY and parameters; 11-bit, no overflow for legal parameters.
- drawBar = (xPos>barLeft)&(xPos<barRight)&(yPos>barTop)&(yPos<barBottom).
  - Strict inequalities on all edges, zero-extended compare.
  - Combinational; drawn area matches the ball's drawing convention.
- Latency from a clean button edge:
  - 2 cycles sync, then DEBOUNCE cycles to the debounced level.
  - +1 cycle for the state update.
  - First move on the next tick.

Test Plan (MOVE_DIV=4, DEBOUNCE=3, STEP=1, DEADBAND=4, other defaults):
- Reset asserted 2 cycles -> barLeft=20, barRight=30, barTop=250, barBottom=350; drawBar=1 at (25,300), 0 at (20,300) and (25,350).
- btnUp pulse of 2 cycles -> debounced never rises, barTop stays 250 for 100 cycles. btnUp held -> state UP within 2+3+1 cycles; barTop then decrements by exactly 1 per 4 cycles (249, 248, ...).
- btnUp held 1100 ticks -> barTop reaches 0 and stays 0 (never 2047); barBottom=100.
- From barTop=495, btnDown held -> barTop 496..500 then holds at 500; barBottom=600.
- btnUp and btnDown both held -> state HOLD, barTop unchanged across 50 ticks.
- autoMode=1, ballTop=100 (bc=110), barTop=250 -> bar moves up and stops at barTop=64 (pc=114). Reset asserted while moving -> barTop=250 on the next cycle and state HOLD; motion resumes only after Reset deasserts.
